axi_2x1_arbiter: RTL and testbench
==================================

Name: axi_2x1_arbiter

Overview:
Merges the instruction AXI3 master (m0) and the data AXI3 master (m1) of the CPU core into one AXI3 master port (s_*) towards the SoC interconnect. It sits directly downstream of the core's inst/data sramlike-to-AXI bridges. Read and write paths are arbitrated independently. Each path carries one burst at a time, with round-robin grant between the two masters.

Parameters:
ID_W, 4, AXI ID width; IDs pass through unchanged.
ADDR_W, 32, address width.
DATA_W, 32, data width; strobe width is DATA_W/8.
WR_BEFORE_RD, 0, when 1, no read grant is issued while the write FSM is not W_IDLE (RAW guard).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mN_arid, mN_araddr, mN_arlen, mN_arsize, mN_arburst, mN_arlock, mN_arcache, mN_arprot, mN_arvalid (N=0,1)  input  ID_W/ADDR_W/8/3/2/2/4/3/1  master read-address channel
mN_arready  output  1  read-address accept
mN_rid, mN_rdata, mN_rresp, mN_rlast  output  ID_W/DATA_W/2/1  read data, broadcast to both masters
mN_rvalid  output  1  read-data valid, granted master only
mN_rready  input  1  master read-data ready
mN_awid, mN_awaddr, mN_awlen, mN_awsize, mN_awburst, mN_awlock, mN_awcache, mN_awprot, mN_awvalid  input  as the ar* bundle  write-address channel
mN_awready  output  1  write-address accept
mN_wid, mN_wdata, mN_wstrb, mN_wlast, mN_wvalid  input  ID_W/DATA_W/DATA_W/8/1/1  write data
mN_wready  output  1  write-data accept
mN_bid, mN_bresp  output  ID_W/2  write response, broadcast to both masters
mN_bvalid  output  1  write-response valid, granted master only
mN_bready  input  1  master response ready
s_ar*, s_aw*, s_w*  output  as the master bundles  merged request channels
s_arready, s_awready, s_wready  input  1  slave request ready
s_rid, s_rdata, s_rresp, s_rlast, s_rvalid  input  ID_W/DATA_W/2/1/1  slave read data
s_rready  output  1  read-data ready to slave
s_bid, s_bresp, s_bvalid  input  ID_W/2/1  slave write response
s_bready  output  1  write-response ready to slave

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Read FSM goes to R_IDLE; write FSM goes to W_IDLE.
  - Read and write priority pointers both point to m1 (data first).
  - All valid/ready outputs are 0 in the cycle after reset. Data and address outputs are don't-care while their valid is 0.
  - Reset mid-burst abandons the burst; the slave is reset by the same rst.
- Read FSM:
  - R_IDLE: if any mN_arvalid is high (and WR_BEFORE_RD=0, or write FSM is W_IDLE), register rgnt from the priority pointer and go to R_ADDR. This costs one bubble cycle; no combinational ready is driven in R_IDLE.
  - R_ADDR: s_ar* = granted master's fields; s_arvalid = m[rgnt]_arvalid; m[rgnt]_arready = s_arready. On s_arvalid & s_arready, go to R_DATA.
  - R_DATA: m[rgnt]_rvalid = s_rvalid; s_rready = m[rgnt]_rready. On a handshake with s_rlast=1, go to R_IDLE and set the pointer to the other master.
- Write FSM:
  - W_IDLE: grant on mN_awvalid from the write priority pointer, then go to W_ADDR.
  - W_ADDR: forward aw of wgnt. On handshake, go to W_DATA.
  - W_DATA: forward w of wgnt (wvalid/wready coupled). On a handshake with wlast=1, go to W_RESP.
  - W_RESP: m[wgnt]_bvalid = s_bvalid; s_bready = m[wgnt]_bready. On handshake, go to W_IDLE and flip the pointer.
  - W signals presented before W_DATA are held off with wready=0; masters must not make AW depend on W acceptance.
- The non-granted master always sees arready, awready, wready, rvalid and bvalid = 0.
- Stray s_rvalid outside R_DATA, or s_bvalid outside W_RESP: s_rready/s_bready stay 0.
- The block enforces no read/write ordering unless WR_BEFORE_RD=1.
- Throughput: a read burst occupies 2 + beats cycles minimum with 0-wait slave. Back-to-back bursts have a 1-cycle idle gap.
- Arlen/awlen/sizes pass through unchanged; no burst splitting.

Decomposition:
- Shared package axi_pkg:
  - typedefs ar_chan_t, aw_chan_t, w_chan_t, r_chan_t, b_chan_t (packed structs)
  - enums rd_state_e {R_IDLE, R_ADDR, R_DATA} and wr_state_e {W_IDLE, W_ADDR, W_DATA, W_RESP}
  - constants AXI_ID_W, AXI_ADDR_W, AXI_DATA_W
- One sub-module: rr_arb2 (2-request round-robin, registered grant, advance input). It is instantiated once for read and once for write.

Test Plan:
- m0 only: arvalid, araddr=0x1FC00000, arlen=15, arid=0 -> s_arvalid one cycle later with the same fields; 16 beats reach m0 with rlast on the 16th; m1_rvalid stays 0 throughout.
- m0 and m1 arvalid in the same cycle after reset (m1 araddr=0x80001000, arlen=7) -> m1 is served first. m0 s_ar appears 1 cycle after m1's rlast handshake; a third simultaneous request is granted to m1 again.
- m1 write: awaddr=0x80002000, awlen=7, wstrb=0xF; wvalid is asserted together with awvalid -> wready=0 until AW completes; 8 W beats with wlast on the 8th; s_bvalid goes only to m1; FSM returns to W_IDLE after bready.
- WR_BEFORE_RD=0, m1 write and m0 read concurrent -> both paths progress in overlap. WR_BEFORE_RD=1, same stimulus -> s_arvalid is delayed until the cycle after the B handshake.
- Backpressure: s_arready low 5 cycles -> s_ar* stable and m0_arready=0. m0_rready toggling -> s_rready mirrors it and no beat is lost or duplicated.
- rst asserted during beat 3 of a 16-beat read -> next cycle all valid/ready outputs are 0. A new m0 request after reset completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3 channel types, FSM encodings and default widths for the 2:1 arbiter.
package axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     id;
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

endpackage

// File: rtl/axi_2x1_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a registered grant.
// The grant is captured when grant_en is high; advance hands priority to the
// requester that did not win the transaction just finished.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  input  logic       advance,
  output logic       gnt
);

  logic ptr_q, ptr_d;
  logic gnt_q, gnt_d;

  // Pick the pointed-to requester if it asks, otherwise the other one.
  always_comb begin
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    if (grant_en) gnt_d = req[ptr_q] ? ptr_q : ~ptr_q;
    if (advance)  ptr_d = ~gnt_q;
  end

  // Priority starts at m1 (data side) after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b1;
      gnt_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/axi_2x1_arbiter.sv
// Merges the instruction (m0) and data (m1) AXI3 masters onto one AXI3 port.
// Read and write paths are arbitrated independently, one burst at a time.
//
// state  | meaning
// R_IDLE | no read burst; register a grant when any arvalid is seen
// R_ADDR | forward AR of the granted master
// R_DATA | forward R beats to the granted master until rlast
// W_IDLE | no write burst; register a grant when any awvalid is seen
// W_ADDR | forward AW of the granted master (W held off)
// W_DATA | forward W beats of the granted master until wlast
// W_RESP | forward B to the granted master
module axi_2x1_arbiter
  import axi_pkg::*;
#(
  parameter int ID_W         = AXI_ID_W,
  parameter int ADDR_W       = AXI_ADDR_W,
  parameter int DATA_W       = AXI_DATA_W,
  parameter int WR_BEFORE_RD = 0
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction)
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic [1:0]        m0_arlock,
  input  logic [3:0]        m0_arcache,
  input  logic [2:0]        m0_arprot,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_W-1:0]   m0_awid,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [7:0]        m0_awlen,
  input  logic [2:0]        m0_awsize,
  input  logic [1:0]        m0_awburst,
  input  logic [1:0]        m0_awlock,
  input  logic [3:0]        m0_awcache,
  input  logic [2:0]        m0_awprot,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ID_W-1:0]   m0_wid,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic              m0_wlast,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic [ID_W-1:0]   m0_bid,
  output logic [1:0]        m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  // master 1 (data)
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic [1:0]        m1_arlock,
  input  logic [3:0]        m1_arcache,
  input  logic [2:0]        m1_arprot,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  input  logic [ID_W-1:0]   m1_awid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic [1:0]        m1_awlock,
  input  logic [3:0]        m1_awcache,
  input  logic [2:0]        m1_awprot,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ID_W-1:0]   m1_wid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [ID_W-1:0]   m1_bid,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // merged slave-side port
  output logic [ID_W-1:0]   s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic [1:0]        s_arlock,
  output logic [3:0]        s_arcache,
  output logic [2:0]        s_arprot,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ID_W-1:0]   s_awid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic [1:0]        s_awlock,
  output logic [3:0]        s_awcache,
  output logic [2:0]        s_awprot,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ID_W-1:0]   s_wid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [ID_W-1:0]   s_bid,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  rd_state_e r_state_q, r_state_d;
  wr_state_e w_state_q, w_state_d;
  logic      rgnt, wgnt;
  logic      r_grant_en, r_advance;
  logic      w_grant_en, w_advance;

  rr_arb2 u_rd_arb (
    .clk(clk), .rst(rst), .req({m1_arvalid, m0_arvalid}),
    .grant_en(r_grant_en), .advance(r_advance), .gnt(rgnt)
  );

  rr_arb2 u_wr_arb (
    .clk(clk), .rst(rst), .req({m1_awvalid, m0_awvalid}),
    .grant_en(w_grant_en), .advance(w_advance), .gnt(wgnt)
  );

  // Request payloads follow the registered grant; they only matter while valid is high.
  assign s_arid    = rgnt ? m1_arid    : m0_arid;
  assign s_araddr  = rgnt ? m1_araddr  : m0_araddr;
  assign s_arlen   = rgnt ? m1_arlen   : m0_arlen;
  assign s_arsize  = rgnt ? m1_arsize  : m0_arsize;
  assign s_arburst = rgnt ? m1_arburst : m0_arburst;
  assign s_arlock  = rgnt ? m1_arlock  : m0_arlock;
  assign s_arcache = rgnt ? m1_arcache : m0_arcache;
  assign s_arprot  = rgnt ? m1_arprot  : m0_arprot;
  assign s_awid    = wgnt ? m1_awid    : m0_awid;
  assign s_awaddr  = wgnt ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = wgnt ? m1_awlen   : m0_awlen;
  assign s_awsize  = wgnt ? m1_awsize  : m0_awsize;
  assign s_awburst = wgnt ? m1_awburst : m0_awburst;
  assign s_awlock  = wgnt ? m1_awlock  : m0_awlock;
  assign s_awcache = wgnt ? m1_awcache : m0_awcache;
  assign s_awprot  = wgnt ? m1_awprot  : m0_awprot;
  assign s_wid     = wgnt ? m1_wid     : m0_wid;
  assign s_wdata   = wgnt ? m1_wdata   : m0_wdata;
  assign s_wstrb   = wgnt ? m1_wstrb   : m0_wstrb;
  assign s_wlast   = wgnt ? m1_wlast   : m0_wlast;

  // Response payloads are broadcast; only the granted master sees valid.
  assign m0_rid   = s_rid;   assign m1_rid   = s_rid;
  assign m0_rdata = s_rdata; assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp; assign m1_rresp = s_rresp;
  assign m0_rlast = s_rlast; assign m1_rlast = s_rlast;
  assign m0_bid   = s_bid;   assign m1_bid   = s_bid;
  assign m0_bresp = s_bresp; assign m1_bresp = s_bresp;

  // FSM state registers for both paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  // Read path: grant bubble in R_IDLE, then AR, then R beats until rlast.
  always_comb begin
    r_state_d  = r_state_q;
    r_grant_en = 1'b0;
    r_advance  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if ((m0_arvalid || m1_arvalid) &&
            ((WR_BEFORE_RD == 0) || (w_state_q == W_IDLE))) begin
          r_grant_en = 1'b1;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid = rgnt ? m1_arvalid : m0_arvalid;
        if (rgnt) m1_arready = s_arready;
        else      m0_arready = s_arready;
        if (s_arvalid && s_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_rready = rgnt ? m1_rready : m0_rready;
        if (rgnt) m1_rvalid = s_rvalid;
        else      m0_rvalid = s_rvalid;
        if (s_rvalid && s_rready && s_rlast) begin
          r_advance = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path: AW first, then W beats until wlast, then the B response.
  always_comb begin
    w_state_d  = w_state_q;
    w_grant_en = 1'b0;
    w_advance  = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (m0_awvalid || m1_awvalid) begin
          w_grant_en = 1'b1;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        s_awvalid = wgnt ? m1_awvalid : m0_awvalid;
        if (wgnt) m1_awready = s_awready;
        else      m0_awready = s_awready;
        if (s_awvalid && s_awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_wvalid = wgnt ? m1_wvalid : m0_wvalid;
        if (wgnt) m1_wready = s_wready;
        else      m0_wready = s_wready;
        if (s_wvalid && s_wready && s_wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_bready = wgnt ? m1_bready : m0_bready;
        if (wgnt) m1_bvalid = s_bvalid;
        else      m0_bvalid = s_bvalid;
        if (s_bvalid && s_bready) begin
          w_advance = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_2x1_arbiter.sv
// Directed bench for axi_2x1_arbiter. Instance a has WR_BEFORE_RD=0,
// instance b has WR_BEFORE_RD=1; both share the same stimulus.
module tb_axi_2x1_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  m0_arid, m1_arid, m0_awid, m1_awid, m0_wid, m1_wid, s_rid, s_bid;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, s_rdata;
  logic [7:0]  m0_arlen, m1_arlen, m0_awlen, m1_awlen;
  logic [2:0]  m0_arsize, m1_arsize, m0_awsize, m1_awsize;
  logic [2:0]  m0_arprot, m1_arprot, m0_awprot, m1_awprot;
  logic [1:0]  m0_arburst, m1_arburst, m0_awburst, m1_awburst;
  logic [1:0]  m0_arlock, m1_arlock, m0_awlock, m1_awlock, s_rresp, s_bresp;
  logic [3:0]  m0_arcache, m1_arcache, m0_awcache, m1_awcache, m0_wstrb, m1_wstrb;
  logic m0_arvalid, m1_arvalid, m0_rready, m1_rready, m0_awvalid, m1_awvalid;
  logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_bready, m1_bready;
  logic s_arready, s_awready, s_wready, s_rlast, s_rvalid, s_bvalid;

  logic a_m0_arready, a_m1_arready, a_m0_rlast, a_m1_rlast, a_m0_rvalid, a_m1_rvalid;
  logic a_m0_awready, a_m1_awready, a_m0_wready, a_m1_wready, a_m0_bvalid, a_m1_bvalid;
  logic a_s_arvalid, a_s_awvalid, a_s_wlast, a_s_wvalid, a_s_rready, a_s_bready;
  logic [3:0]  a_m0_rid, a_m1_rid, a_m0_bid, a_m1_bid, a_s_arid, a_s_awid, a_s_wid;
  logic [3:0]  a_s_arcache, a_s_awcache, a_s_wstrb;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_araddr, a_s_awaddr, a_s_wdata;
  logic [1:0]  a_m0_rresp, a_m1_rresp, a_m0_bresp, a_m1_bresp;
  logic [1:0]  a_s_arburst, a_s_arlock, a_s_awburst, a_s_awlock;
  logic [7:0]  a_s_arlen, a_s_awlen;
  logic [2:0]  a_s_arsize, a_s_arprot, a_s_awsize, a_s_awprot;

  logic b_m0_arready, b_m1_arready, b_m0_rlast, b_m1_rlast, b_m0_rvalid, b_m1_rvalid;
  logic b_m0_awready, b_m1_awready, b_m0_wready, b_m1_wready, b_m0_bvalid, b_m1_bvalid;
  logic b_s_arvalid, b_s_awvalid, b_s_wlast, b_s_wvalid, b_s_rready, b_s_bready;
  logic [3:0]  b_m0_rid, b_m1_rid, b_m0_bid, b_m1_bid, b_s_arid, b_s_awid, b_s_wid;
  logic [3:0]  b_s_arcache, b_s_awcache, b_s_wstrb;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_araddr, b_s_awaddr, b_s_wdata;
  logic [1:0]  b_m0_rresp, b_m1_rresp, b_m0_bresp, b_m1_bresp;
  logic [1:0]  b_s_arburst, b_s_arlock, b_s_awburst, b_s_awlock;
  logic [7:0]  b_s_arlen, b_s_awlen;
  logic [2:0]  b_s_arsize, b_s_arprot, b_s_awsize, b_s_awprot;

  axi_2x1_arbiter #(.WR_BEFORE_RD(0)) dut_a (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arlock(m0_arlock), .m0_arcache(m0_arcache), .m0_arprot(m0_arprot),
    .m0_arvalid(m0_arvalid), .m0_arready(a_m0_arready),
    .m0_rid(a_m0_rid), .m0_rdata(a_m0_rdata), .m0_rresp(a_m0_rresp), .m0_rlast(a_m0_rlast),
    .m0_rvalid(a_m0_rvalid), .m0_rready(m0_rready),
    .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
    .m0_awburst(m0_awburst), .m0_awlock(m0_awlock), .m0_awcache(m0_awcache), .m0_awprot(m0_awprot),
    .m0_awvalid(m0_awvalid), .m0_awready(a_m0_awready),
    .m0_wid(m0_wid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wvalid(m0_wvalid), .m0_wready(a_m0_wready),
    .m0_bid(a_m0_bid), .m0_bresp(a_m0_bresp), .m0_bvalid(a_m0_bvalid), .m0_bready(m0_bready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arlock(m1_arlock), .m1_arcache(m1_arcache), .m1_arprot(m1_arprot),
    .m1_arvalid(m1_arvalid), .m1_arready(a_m1_arready),
    .m1_rid(a_m1_rid), .m1_rdata(a_m1_rdata), .m1_rresp(a_m1_rresp), .m1_rlast(a_m1_rlast),
    .m1_rvalid(a_m1_rvalid), .m1_rready(m1_rready),
    .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awlock(m1_awlock), .m1_awcache(m1_awcache), .m1_awprot(m1_awprot),
    .m1_awvalid(m1_awvalid), .m1_awready(a_m1_awready),
    .m1_wid(m1_wid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wvalid(m1_wvalid), .m1_wready(a_m1_wready),
    .m1_bid(a_m1_bid), .m1_bresp(a_m1_bresp), .m1_bvalid(a_m1_bvalid), .m1_bready(m1_bready),
    .s_arid(a_s_arid), .s_araddr(a_s_araddr), .s_arlen(a_s_arlen), .s_arsize(a_s_arsize),
    .s_arburst(a_s_arburst), .s_arlock(a_s_arlock), .s_arcache(a_s_arcache), .s_arprot(a_s_arprot),
    .s_arvalid(a_s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(a_s_rready),
    .s_awid(a_s_awid), .s_awaddr(a_s_awaddr), .s_awlen(a_s_awlen), .s_awsize(a_s_awsize),
    .s_awburst(a_s_awburst), .s_awlock(a_s_awlock), .s_awcache(a_s_awcache), .s_awprot(a_s_awprot),
    .s_awvalid(a_s_awvalid), .s_awready(s_awready),
    .s_wid(a_s_wid), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wlast(a_s_wlast),
    .s_wvalid(a_s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(a_s_bready)
  );

  axi_2x1_arbiter #(.WR_BEFORE_RD(1)) dut_b (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arlock(m0_arlock), .m0_arcache(m0_arcache), .m0_arprot(m0_arprot),
    .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
    .m0_rid(b_m0_rid), .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rlast(b_m0_rlast),
    .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
    .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
    .m0_awburst(m0_awburst), .m0_awlock(m0_awlock), .m0_awcache(m0_awcache), .m0_awprot(m0_awprot),
    .m0_awvalid(m0_awvalid), .m0_awready(b_m0_awready),
    .m0_wid(m0_wid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wvalid(m0_wvalid), .m0_wready(b_m0_wready),
    .m0_bid(b_m0_bid), .m0_bresp(b_m0_bresp), .m0_bvalid(b_m0_bvalid), .m0_bready(m0_bready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arlock(m1_arlock), .m1_arcache(m1_arcache), .m1_arprot(m1_arprot),
    .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
    .m1_rid(b_m1_rid), .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rlast(b_m1_rlast),
    .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
    .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awlock(m1_awlock), .m1_awcache(m1_awcache), .m1_awprot(m1_awprot),
    .m1_awvalid(m1_awvalid), .m1_awready(b_m1_awready),
    .m1_wid(m1_wid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wvalid(m1_wvalid), .m1_wready(b_m1_wready),
    .m1_bid(b_m1_bid), .m1_bresp(b_m1_bresp), .m1_bvalid(b_m1_bvalid), .m1_bready(m1_bready),
    .s_arid(b_s_arid), .s_araddr(b_s_araddr), .s_arlen(b_s_arlen), .s_arsize(b_s_arsize),
    .s_arburst(b_s_arburst), .s_arlock(b_s_arlock), .s_arcache(b_s_arcache), .s_arprot(b_s_arprot),
    .s_arvalid(b_s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(b_s_rready),
    .s_awid(b_s_awid), .s_awaddr(b_s_awaddr), .s_awlen(b_s_awlen), .s_awsize(b_s_awsize),
    .s_awburst(b_s_awburst), .s_awlock(b_s_awlock), .s_awcache(b_s_awcache), .s_awprot(b_s_awprot),
    .s_awvalid(b_s_awvalid), .s_awready(s_awready),
    .s_wid(b_s_wid), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wlast(b_s_wlast),
    .s_wvalid(b_s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(b_s_bready)
  );

  int errors = 0;
  int checks = 0;
  int k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every valid/ready output of both instances must be low.
  task automatic chk_idle(input string tag);
    chk({tag, "_a"}, {a_s_arvalid, a_s_awvalid, a_s_wvalid, a_s_rready, a_s_bready,
                      a_m0_arready, a_m1_arready, a_m0_awready, a_m1_awready,
                      a_m0_wready, a_m1_wready, a_m0_rvalid, a_m1_rvalid,
                      a_m0_bvalid, a_m1_bvalid}, 64'd0);
    chk({tag, "_b"}, {b_s_arvalid, b_s_awvalid, b_s_wvalid, b_s_rready, b_s_bready,
                      b_m0_arready, b_m1_arready, b_m0_awready, b_m1_awready,
                      b_m0_wready, b_m1_wready, b_m0_rvalid, b_m1_rvalid,
                      b_m0_bvalid, b_m1_bvalid}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {m0_arid, m1_arid, m0_awid, m1_awid, m0_wid, m1_wid, s_rid, s_bid} = '0;
    {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, s_rdata} = '0;
    {m0_arlen, m1_arlen, m0_awlen, m1_awlen} = '0;
    {m0_arsize, m1_arsize, m0_awsize, m1_awsize} = {4{3'd2}};
    {m0_arburst, m1_arburst, m0_awburst, m1_awburst} = {4{2'd1}};
    {m0_arprot, m1_arprot, m0_awprot, m1_awprot} = '0;
    {m0_arlock, m1_arlock, m0_awlock, m1_awlock, s_rresp, s_bresp} = '0;
    {m0_arcache, m1_arcache, m0_awcache, m1_awcache} = '0;
    m0_wstrb = 4'hF; m1_wstrb = 4'hF;
    {m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid} = '0;
    {m0_wlast, m1_wlast} = '0;
    {m0_rready, m1_rready, m0_bready, m1_bready} = 4'hF;
    {s_arready, s_awready, s_wready, s_rlast, s_rvalid, s_bvalid} = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_idle("reset");

    // Stray slave responses while idle are not accepted or forwarded.
    s_rvalid = 1'b1; s_bvalid = 1'b1; #1;
    chk("stray_rready", a_s_rready, 0);
    chk("stray_bready", a_s_bready, 0);
    chk("stray_fwd", {a_m0_rvalid, a_m1_rvalid, a_m0_bvalid, a_m1_bvalid}, 0);
    s_rvalid = 1'b0; s_bvalid = 1'b0;

    // m0 alone: 16-beat read.
    m0_arid = 4'd0; m0_araddr = 32'h1FC0_0000; m0_arlen = 8'd15; m0_arvalid = 1'b1;
    s_arready = 1'b1; #1;
    chk("t1_bubble_arvalid", a_s_arvalid, 0);
    chk("t1_bubble_arready", a_m0_arready, 0);
    tick();
    chk("t1_s_arvalid", a_s_arvalid, 1);
    chk("t1_s_araddr", a_s_araddr, 32'h1FC0_0000);
    chk("t1_s_arlen", a_s_arlen, 15);
    chk("t1_s_arid", a_s_arid, 0);
    chk("t1_m0_arready", a_m0_arready, 1);
    chk("t1_m1_arready", a_m1_arready, 0);
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'hA000 + i; s_rlast = (i == 15); #1;
      chk("t1_m0_rvalid", a_m0_rvalid, 1);
      chk("t1_m0_rdata", a_m0_rdata, 32'hA000 + i);
      chk("t1_m0_rlast", a_m0_rlast, (i == 15));
      chk("t1_m1_rvalid", a_m1_rvalid, 0);
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    chk_idle("t1_done");

    // Simultaneous requests: m1 first, then m0, then m1 wins again.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0040; m0_arlen = 8'd0;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000; m1_arlen = 8'd7; m1_arid = 4'd1;
    s_arready = 1'b1;
    tick();
    chk("t2_gnt_addr", a_s_araddr, 32'h8000_1000);
    chk("t2_gnt_len", a_s_arlen, 7);
    chk("t2_gnt_id", a_s_arid, 1);
    chk("t2_m1_arready", a_m1_arready, 1);
    chk("t2_m0_arready", a_m0_arready, 0);
    tick();
    m1_arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'hC000 + i; s_rlast = (i == 7); #1;
      chk("t2_m1_rvalid", a_m1_rvalid, 1);
      chk("t2_m1_rdata", a_m1_rdata, 32'hC000 + i);
      chk("t2_m0_rvalid", a_m0_rvalid, 0);
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    chk("t2_gap", a_s_arvalid, 0);
    tick();
    chk("t2_m0_addr", a_s_araddr, 32'h1FC0_0040);
    chk("t2_m0_arready", a_m0_arready, 1);
    tick();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h0000_00DD; #1;
    chk("t2_m0_beat", {a_m0_rvalid, a_m1_rvalid}, 2'b10);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_araddr = 32'h8000_1040;
    tick();
    chk("t2_third_addr", a_s_araddr, 32'h8000_1040);
    chk("t2_third_rdy", {a_m1_arready, a_m0_arready}, 2'b10);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // m1 write, W offered together with AW.
    do_reset();
    m1_awid = 4'd2; m1_awaddr = 32'h8000_2000; m1_awlen = 8'd7; m1_awvalid = 1'b1;
    m1_wid = 4'd2; m1_wdata = 32'hD000; m1_wstrb = 4'hF; m1_wlast = 1'b0; m1_wvalid = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; #1;
    chk("t3_idle_wready", a_m1_wready, 0);
    chk("t3_idle_swvalid", a_s_wvalid, 0);
    tick();
    chk("t3_s_awvalid", a_s_awvalid, 1);
    chk("t3_s_awaddr", a_s_awaddr, 32'h8000_2000);
    chk("t3_s_awlen", a_s_awlen, 7);
    chk("t3_awready", {a_m1_awready, a_m0_awready}, 2'b10);
    chk("t3_addr_wready", a_m1_wready, 0);
    chk("t3_addr_swvalid", a_s_wvalid, 0);
    tick();
    m1_awvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m1_wdata = 32'hD000 + i; m1_wlast = (i == 7); #1;
      chk("t3_s_wvalid", a_s_wvalid, 1);
      chk("t3_s_wdata", a_s_wdata, 32'hD000 + i);
      chk("t3_s_wlast", a_s_wlast, (i == 7));
      chk("t3_s_wstrb", a_s_wstrb, 4'hF);
      chk("t3_wready", {a_m1_wready, a_m0_wready}, 2'b10);
      tick();
    end
    m1_wvalid = 1'b0; m1_wlast = 1'b0;
    s_bvalid = 1'b1; s_bid = 4'd2; s_bresp = 2'd0; #1;
    chk("t3_bvalid", {a_m1_bvalid, a_m0_bvalid}, 2'b10);
    chk("t3_s_bready", a_s_bready, 1);
    chk("t3_m1_bid", a_m1_bid, 2);
    tick();
    s_bvalid = 1'b0; #1;
    chk_idle("t3_done");
    s_bvalid = 1'b1; #1;
    chk("t3_stray_b", a_s_bready, 0);
    s_bvalid = 1'b0;

    // Concurrent m1 write and m0 read on both instances.
    do_reset();
    m1_awaddr = 32'h8000_3000; m1_awlen = 8'd0; m1_awvalid = 1'b1;
    m1_wdata = 32'hE0; m1_wlast = 1'b1; m1_wvalid = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    tick();
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0080; m0_arlen = 8'd0; #1;
    chk("t4_awvalid", {a_s_awvalid, b_s_awvalid}, 2'b11);
    tick();
    m1_awvalid = 1'b0; #1;
    chk("t4_a_overlap", {a_s_arvalid, a_s_wvalid}, 2'b11);
    chk("t4_b_held", {b_s_arvalid, b_s_wvalid}, 2'b01);
    tick();
    m1_wvalid = 1'b0; m1_wlast = 1'b0; s_bvalid = 1'b1; #1;
    chk("t4_bvalid", {a_m1_bvalid, b_m1_bvalid}, 2'b11);
    chk("t4_b_held_resp", b_s_arvalid, 0);
    tick();
    s_bvalid = 1'b0; #1;
    chk("t4_b_after_b", b_s_arvalid, 0);
    chk("t4_a_in_data", a_s_arvalid, 0);
    tick();
    chk("t4_b_arvalid", b_s_arvalid, 1);
    chk("t4_b_araddr", b_s_araddr, 32'h1FC0_0080);
    chk("t4_b_arready", b_m0_arready, 1);
    tick();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hF0; #1;
    chk("t4_rvalid", {a_m0_rvalid, b_m0_rvalid}, 2'b11);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b0; #1;
    chk_idle("t4_done");

    // Backpressure: AR stall, then toggling rready.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0100; m0_arlen = 8'd3; m0_arid = 4'd3;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk("t5_stall_arvalid", a_s_arvalid, 1);
      chk("t5_stall_araddr", a_s_araddr, 32'h1FC0_0100);
      chk("t5_stall_arlen", a_s_arlen, 3);
      chk("t5_stall_arready", a_m0_arready, 0);
      tick();
    end
    s_arready = 1'b1; #1;
    chk("t5_arready", a_m0_arready, 1);
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    k = 0;
    for (int j = 0; j < 20 && k < 4; j++) begin
      m0_rready = (j % 2 == 1); s_rvalid = 1'b1; s_rdata = 32'hB0 + k; s_rlast = (k == 3); #1;
      chk("t5_s_rready", a_s_rready, (j % 2 == 1));
      chk("t5_m0_rvalid", a_m0_rvalid, 1);
      chk("t5_m0_rdata", a_m0_rdata, 32'hB0 + k);
      tick();
      if (j % 2 == 1) k++;
    end
    chk("t5_beats", k, 4);
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b1; #1;
    chk("t5_done_rready", a_s_rready, 0);

    // Reset during beat 3 of a 16-beat read, then a fresh read.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0200; m0_arlen = 8'd15; s_arready = 1'b1;
    tick();
    tick();
    m0_arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'h100 + i; s_rlast = 1'b0;
      tick();
    end
    s_rdata = 32'h102; rst = 1'b1; #1;
    chk("t6_beat3", a_m0_rvalid, 1);
    tick();
    rst = 1'b0; s_rvalid = 1'b0; #1;
    chk_idle("t6_after_rst");
    s_rvalid = 1'b1; #1;
    chk("t6_stray_r", a_s_rready, 0);
    s_rvalid = 1'b0;
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0300; m0_arlen = 8'd1;
    tick();
    chk("t6_new_arvalid", a_s_arvalid, 1);
    chk("t6_new_araddr", a_s_araddr, 32'h1FC0_0300);
    tick();
    m0_arvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'h300 + i; s_rlast = (i == 1); #1;
      chk("t6_new_beat", {a_m0_rvalid, a_m0_rlast}, {1'b1, (i == 1)});
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b0; #1;
    chk_idle("t6_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
